// File: rtl/instr_encoder_if.sv
// Field-bundle and encoded-word bus for instr_encoder.
// Master drives bundles and consumes words; slave is the encoder.
interface instr_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_kind;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [2:0]  funct3;
  logic [31:0] imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_addr;
  logic        out_err;
  logic [15:0] out_count;

  modport master (
    output in_valid, in_kind, rd, rs1, rs2,
    output funct3, imm, out_ready,
    input  in_ready, out_valid, out_instr,
    input  out_addr, out_err, out_count
  );

  modport slave (
    input  in_valid, in_kind, rd, rs1, rs2,
    input  funct3, imm, out_ready,
    output in_ready, out_valid, out_instr,
    output out_addr, out_err, out_count
  );
endinterface

// File: rtl/instr_encoder.sv
// Encodes I/S/B field bundles into RV32 words with address stamp.
// Results pass through a 2-entry FIFO toward the consumer.
module instr_encoder (
  input logic             clk,
  input logic             reset,
  instr_encoder_if.slave  bus
);

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] addr;
    logic        err;
  } entry_t;

  entry_t      mem [2];
  logic        wp;
  logic        rp;
  logic [1:0]  occ;
  logic [31:0] addr_q;
  logic [15:0] cnt_q;

  logic signed [31:0] simm;
  logic [31:0] enc;
  logic        bad;
  logic        nonempty;
  logic        show;
  logic        acc;
  logic        del;

  assign simm     = bus.imm;
  assign nonempty = (occ != 2'd0);
  assign acc      = bus.in_valid && bus.in_ready;
  assign del      = nonempty && bus.out_ready;

  // Format selection, range/alignment check, and bit packing.
  always_comb begin
    enc = '0;
    bad = 1'b0;
    unique case (bus.in_kind)
      2'b00: begin
        bad = (simm < -32'sd2048) || (simm > 32'sd2047);
        enc = {bus.imm[11:0], bus.rs1, bus.funct3,
               bus.rd, 7'b0000011};
      end
      2'b01: begin
        bad = (simm < -32'sd2048) || (simm > 32'sd2047);
        enc = {bus.imm[11:5], bus.rs2, bus.rs1,
               bus.funct3, bus.imm[4:0], 7'b0100011};
      end
      2'b10: begin
        bad = (simm < -32'sd4096) || (simm > 32'sd4094)
              || bus.imm[0];
        enc = {bus.imm[12], bus.imm[10:5], bus.rs2,
               bus.rs1, bus.funct3, bus.imm[4:1],
               bus.imm[11], 7'b1100011};
      end
      default: bad = 1'b1;
    endcase
    if (bad) enc = '0;
  end

  // FIFO storage; contents are don't-care while unoccupied.
  always_ff @(posedge clk) begin
    if (acc) mem[wp] <= '{instr: enc, addr: addr_q, err: bad};
  end

  // Pointers, occupancy, address stamp and delivery counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      wp     <= 1'b0;
      rp     <= 1'b0;
      occ    <= 2'd0;
      addr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (acc) begin
        wp     <= ~wp;
        addr_q <= addr_q + 32'd4;
      end
      if (del) begin
        rp <= ~rp;
        if (cnt_q != 16'hFFFF) cnt_q <= cnt_q + 16'd1;
      end
      unique case ({acc, del})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
    end
  end

  // Outputs read zero whenever nothing is presentable.
  assign show          = nonempty && !reset;
  assign bus.out_valid = show;
  assign bus.out_instr = show ? mem[rp].instr : '0;
  assign bus.out_addr  = show ? mem[rp].addr : '0;
  assign bus.out_err   = show ? mem[rp].err : 1'b0;
  assign bus.in_ready  = (occ < 2'd2);
  assign bus.out_count = cnt_q;

endmodule
